ysyx_22041207_muldiv_ctrl: RTL
==============================

Name: ysyx_22041207_muldiv_ctrl

Overview:
- Sequencer between the EX-stage ALU and the shared iterative multiplier and divider units.
- Accepts one M-extension request at a time, prepares the operands and drives the unit's valid/ready handshake.
- Stalls the pipeline while the unit works, then formats the result (high/low half, word sign-extension).
- Resolves divide-by-zero and signed overflow locally without dispatching; honours pipeline flush.

Parameters:
- XLEN, 64, datapath width. The block is specified and verified at 64 only.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the in-flight op
- req_valid  in  1  EX stage presents an M op; held while busy=1
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_word  in  1  *W variant (32-bit op)
- req_a  in  64  rs1
- req_b  in  64  rs2
- busy  out  1  pipeline stall (combinational)
- res_valid  out  1  result valid, one-cycle pulse
- res  out  64  result (registered)
- mul_valid  out  1  request to multiplier
- mul_ready  in  1  multiplier accepts
- mul_a  out  64  multiplier operand A
- mul_b  out  64  multiplier operand B
- mul_sign  out  2  {a_signed, b_signed}
- mul_out_valid  in  1  product ready
- mul_hi  in  64  product bits 127:64
- mul_lo  in  64  product bits 63:0
- mul_flush  out  1  abort multiplier
- div_valid  out  1  request to divider
- div_ready  in  1  divider accepts
- div_a  out  64  dividend
- div_b  out  64  divisor
- div_sign  out  1  signed divide
- div_out_valid  in  1  divide result ready
- div_quot  in  64  quotient
- div_rem  in  64  remainder
- div_flush  out  1  abort divider

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset → IDLE; res=0, res_valid=0, mul_valid=0, div_valid=0, flush outputs 0.
- busy = (IDLE & req_valid & ~flush) | ISSUE | WAIT. busy is 0 in DONE.
- IDLE, req_valid=1, flush=0: latch op, word and prepared operands.
  - Divide op with zero divisor, or signed overflow: go to DONE with the special result.
  - Otherwise: go to ISSUE.
- Operand prep, word mul: both operands sign-extended from bits 31:0.
- Operand prep, word div/rem: sign-extend if signed op, zero-extend if unsigned.
- Zero and overflow tests use the prepared operands.
- mul_sign: MUL/MULH = 11, MULHSU = 10, MULHU = 00, word = 11. div_sign = op ∈ {DIV, REM}.
- ISSUE: assert the selected unit's valid with stable operands. Leave for WAIT on the cycle valid&ready is sampled high. valid drops in the next cycle.
- WAIT: hold until out_valid. On out_valid, register the formatted result into res and go to DONE.
- Result selection:
  - MUL → lo; MULH/MULHSU/MULHU → hi.
  - DIV/DIVU → quot; REM/REMU → rem.
  - Word ops: res = sign-extend of bits 31:0 of the selected value.
- Special results:
  - Divide by zero: quot = all ones (word: sign-extend 0xFFFFFFFF), rem = dividend.
  - Signed overflow (−2^63/−1, or −2^31/−1 for word): quot = dividend, rem = 0.
- DONE: res_valid=1 for exactly one cycle, then IDLE. A req_valid seen in DONE is the same instruction advancing and is ignored.
- Earliest new accept is the cycle after DONE.
- res holds its value until the next completion.
- Normal-op latency = 1 (accept) + handshake cycles + unit latency + 1 (DONE). Special path: res_valid two cycles after the accept edge.
- flush has priority over every event. In any state, next state is IDLE.
  - Valid outputs are cleared.
  - The selected unit's *_flush is pulsed for one cycle, registered, only when leaving ISSUE or WAIT.
  - An out_valid coinciding with flush is discarded: res unchanged, no res_valid.
  - flush in DONE suppresses nothing: res_valid has already been driven that cycle.
- out_valid from the unselected unit, or out_valid seen in a state other than WAIT: ignored.
- rst mid-operation: as reset; no flush pulse is required.

Test Plan:
- MUL a=3, b=−5 (0xFFFF…FFFB), unit latency 4 → res=0xFFFFFFFFFFFFFFF1 with one res_valid pulse; busy high from the accept cycle until DONE; mul_sign=11.
- MULHU a=b=0xFFFFFFFFFFFFFFFF → mul_sign=00, res=0xFFFFFFFFFFFFFFFE; mul_ready held low 3 cycles → mul_valid stays high and operands stable throughout.
- DIVW a=0x00000000_80000000, b=0xFFFFFFFF → no div_valid; res=0xFFFFFFFF80000000 two cycles after accept. REMW on the same operands → res=0.
- DIVU b=0 a=7 → res=0xFFFFFFFFFFFFFFFF. REMU b=0 a=7 → res=7. Neither case issues div_valid.
- DIV −20/3 → res=−6. Raise flush during WAIT coincident with div_out_valid → next state IDLE, div_flush pulse, no res_valid, res keeps its prior value.
- Back-to-back: MUL followed next cycle by DIVU 100/7 → second request accepted only after DONE; results 0x… then 14; req_valid held through DONE is not double-accepted.

Source files
------------

// File: rtl/ysyx_22041207_muldiv_ctrl.sv
// Sequencer between the EX-stage ALU and the shared iterative multiplier/divider.
// Prepares operands, runs the valid/ready handshake, formats results and handles div special cases.
module ysyx_22041207_muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_req_valid,
  input  logic [2:0]      i_req_op,
  input  logic            i_req_word,
  input  logic [XLEN-1:0] i_req_a,
  input  logic [XLEN-1:0] i_req_b,
  output logic            o_busy,
  output logic            o_res_valid,
  output logic [XLEN-1:0] o_res,
  output logic            o_mul_valid,
  input  logic            i_mul_ready,
  output logic [XLEN-1:0] o_mul_a,
  output logic [XLEN-1:0] o_mul_b,
  output logic [1:0]      o_mul_sign,
  input  logic            i_mul_out_valid,
  input  logic [XLEN-1:0] i_mul_hi,
  input  logic [XLEN-1:0] i_mul_lo,
  output logic            o_mul_flush,
  output logic            o_div_valid,
  input  logic            i_div_ready,
  output logic [XLEN-1:0] o_div_a,
  output logic [XLEN-1:0] o_div_b,
  output logic            o_div_sign,
  input  logic            i_div_out_valid,
  input  logic [XLEN-1:0] i_div_quot,
  input  logic [XLEN-1:0] i_div_rem,
  output logic            o_div_flush
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          r_state, w_nextState;
  logic [2:0]      r_op;
  logic            r_word;
  logic [XLEN-1:0] r_a, r_b, r_res;
  logic [1:0]      r_mulSign;
  logic            r_mulFlush, r_divFlush;

  logic            w_isDivReq, w_divSignedReq, w_accept, w_special;
  logic            w_divZero, w_overflow, w_selReady, w_selOutValid, w_inFlight;
  logic [XLEN-1:0] w_prepA, w_prepB, w_minVal, w_specialRaw, w_unitRes;
  logic [1:0]      w_mulSignReq;

  // Word results are always the low 32 bits sign-extended to XLEN.
  function automatic logic [XLEN-1:0] fmtWord(input logic word, input logic [XLEN-1:0] v);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign w_isDivReq     = i_req_op[2];
  assign w_divSignedReq = i_req_op[2] & ~i_req_op[0];
  assign w_accept       = (r_state == IDLE) & i_req_valid & ~i_flush;
  assign w_inFlight     = (r_state == ISSUE) | (r_state == WAIT);

  always_comb begin
    w_prepA = i_req_a;
    w_prepB = i_req_b;
    if (i_req_word) begin
      if (!w_isDivReq || w_divSignedReq) begin
        w_prepA = {{(XLEN-32){i_req_a[31]}}, i_req_a[31:0]};
        w_prepB = {{(XLEN-32){i_req_b[31]}}, i_req_b[31:0]};
      end else begin
        w_prepA = {{(XLEN-32){1'b0}}, i_req_a[31:0]};
        w_prepB = {{(XLEN-32){1'b0}}, i_req_b[31:0]};
      end
    end
  end

  always_comb begin
    w_mulSignReq = 2'b11;
    if (!i_req_word) begin
      case (i_req_op)
        3'd2:    w_mulSignReq = 2'b10;
        3'd3:    w_mulSignReq = 2'b00;
        default: w_mulSignReq = 2'b11;
      endcase
    end
  end

  // Overflow is checked on prepared operands, so the word case compares against sign-extended -2^31.
  assign w_minVal   = i_req_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_divZero  = w_isDivReq & (w_prepB == '0);
  assign w_overflow = w_divSignedReq & (w_prepA == w_minVal) & (w_prepB == '1);
  assign w_special  = w_divZero | w_overflow;

  always_comb begin
    if (w_divZero) w_specialRaw = i_req_op[1] ? w_prepA : '1;
    else           w_specialRaw = i_req_op[1] ? '0 : w_prepA;
  end

  assign w_selReady    = r_op[2] ? i_div_ready : i_mul_ready;
  assign w_selOutValid = r_op[2] ? i_div_out_valid : i_mul_out_valid;

  always_comb begin
    if (r_op[2])          w_unitRes = r_op[1] ? i_div_rem : i_div_quot;
    else if (r_op == 3'd0) w_unitRes = i_mul_lo;
    else                  w_unitRes = i_mul_hi;
  end

  always_comb begin
    w_nextState = r_state;
    if (i_flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_req_valid) w_nextState = w_special ? DONE : ISSUE;
        ISSUE:   if (w_selReady) w_nextState = WAIT;
        WAIT:    if (w_selOutValid) w_nextState = DONE;
        DONE:    w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Flush pulses are registered so the aborted unit sees a clean one-cycle strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_word     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_mulSign  <= '0;
      r_mulFlush <= 1'b0;
      r_divFlush <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_mulFlush <= i_flush & w_inFlight & ~r_op[2];
      r_divFlush <= i_flush & w_inFlight & r_op[2];
      if (w_accept) begin
        r_op      <= i_req_op;
        r_word    <= i_req_word;
        r_a       <= w_prepA;
        r_b       <= w_prepB;
        r_mulSign <= w_mulSignReq;
        if (w_special) r_res <= fmtWord(i_req_word, w_specialRaw);
      end
      if ((r_state == WAIT) && w_selOutValid && !i_flush) begin
        r_res <= fmtWord(r_word, w_unitRes);
      end
    end
  end

  assign o_busy      = w_accept | w_inFlight;
  assign o_res_valid = (r_state == DONE);
  assign o_res       = r_res;
  assign o_mul_valid = (r_state == ISSUE) & ~r_op[2] & ~i_flush;
  assign o_div_valid = (r_state == ISSUE) & r_op[2] & ~i_flush;
  assign o_mul_a     = r_a;
  assign o_mul_b     = r_b;
  assign o_mul_sign  = r_mulSign;
  assign o_div_a     = r_a;
  assign o_div_b     = r_b;
  assign o_div_sign  = r_op[2] & ~r_op[0];
  assign o_mul_flush = r_mulFlush;
  assign o_div_flush = r_divFlush;

endmodule
